// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the iterative RV64M multiply/divide unit: opcodes,
// internal op codes, FSM states and operand-signedness helpers.
package alu_muldiv_seq_pkg;

    localparam logic [4:0] OPNULL   = 5'd0;
    localparam logic [4:0] OPMUL    = 5'd16;
    localparam logic [4:0] OPMULH   = 5'd17;
    localparam logic [4:0] OPMULHSU = 5'd18;
    localparam logic [4:0] OPMULHU  = 5'd19;
    localparam logic [4:0] OPDIV    = 5'd20;
    localparam logic [4:0] OPDIVU   = 5'd21;
    localparam logic [4:0] OPREM    = 5'd22;
    localparam logic [4:0] OPREMU   = 5'd23;

    // Low three opcode bits; bit 2 selects divide, bit 1 selects remainder within divide.
    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic signed_a(input logic [2:0] f);
        return !(f == F_MULHU || f == F_DIVU || f == F_REMU);
    endfunction

    function automatic logic signed_b(input logic [2:0] f);
        return f == F_MUL || f == F_MULH || f == F_DIV || f == F_REM;
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_step.sv
// One radix-2 iteration: shift-add for multiply, compare-subtract-shift for
// restoring divide. {hi,lo} is the working pair, m the latched operand.
module alu_muldiv_seq_step #(
    parameter int WIDTH = 64
) (
    input  logic             div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        rsh  = {hi, lo[WIDTH-1]};
        ge   = rsh >= {1'b0, m};
        // When ge the difference is below m, so it always fits in WIDTH bits.
        diff = rsh[WIDTH-1:0] - m;
        if (div) begin
            hi_n = ge ? diff : rsh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV64M multiply/divide unit: magnitude datapath, WIDTH iterations,
// sign fix-up at the end, and single-cycle fast paths for the special cases.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 5
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iValid,
    output logic              oReady,
    input  logic [CTRL_W-1:0] iControl,
    input  logic [WIDTH-1:0]  iA,
    input  logic [WIDTH-1:0]  iB,
    input  logic              iKill,
    output logic              oValid,
    input  logic              iReady,
    output logic [WIDTH-1:0]  oResult,
    output logic              oZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [2:0]       f3;
    logic             neg_q, neg_r, zero;
    logic [WIDTH-1:0] hi, lo, m, result;
    logic [WIDTH-1:0] hi_n, lo_n;

    alu_muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .div  (f3[2]),
        .hi   (hi),
        .lo   (lo),
        .m    (m),
        .hi_n (hi_n),
        .lo_n (lo_n)
    );

    logic             m_op, sa, sb, fast;
    logic [2:0]       f3_in;
    logic [WIDTH-1:0] mag_a, mag_b, fast_res;

    always_comb begin
        m_op     = iControl >= CTRL_W'(OPMUL) && iControl <= CTRL_W'(OPREMU);
        f3_in    = iControl[2:0];
        sa       = signed_a(f3_in) && iA[WIDTH-1];
        sb       = signed_b(f3_in) && iB[WIDTH-1];
        mag_a    = sa ? -iA : iA;
        mag_b    = sb ? -iB : iB;
        fast     = 1'b0;
        fast_res = '0;
        if (!m_op) begin
            fast = 1'b1;
        end else if (f3_in[2] && iB == '0) begin
            fast     = 1'b1;
            fast_res = f3_in[1] ? iA : '1;
        end else if ((f3_in == F_DIV || f3_in == F_REM) && iA == MIN && iB == '1) begin
            fast     = 1'b1;
            fast_res = f3_in[1] ? '0 : MIN;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fin;

    always_comb begin
        prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo  = neg_q ? -lo_n : lo_n;
        rem  = neg_r ? -hi_n : hi_n;
        case (f3)
            F_MUL:                      fin = prod[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fin = prod[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:              fin = quo;
            default:                    fin = rem;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            f3     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            result <= '0;
            zero   <= 1'b0;
        end else if (iKill) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (iValid) begin
                    f3    <= f3_in;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    cnt   <= CW'(WIDTH-1);
                    hi    <= '0;
                    // Multiply iterates over B's bits; divide shifts A in as the dividend.
                    lo    <= f3_in[2] ? mag_a : mag_b;
                    m     <= f3_in[2] ? mag_b : mag_a;
                    if (fast) begin
                        result <= fast_res;
                        zero   <= fast_res == '0;
                        state  <= S_DONE;
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= fin;
                        zero   <= fin == '0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: if (iReady) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oReady  = state == S_IDLE;
    assign oValid  = state == S_DONE;
    assign oResult = result;
    assign oZero   = zero && state == S_DONE;

endmodule
